// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchronizer, debouncer and auto-repeat strobe generator
module key_conditioner_ch #(
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000,
  parameter int REPEAT_EN        = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o
);
  localparam int DW   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  logic [1:0]    sync_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    state_q, state_d;
  logic          level_q, level_d, press_q, press_d, rel_q, rel_d, step_q, step_d;
  logic          s, flip;
  assign s = ~sync_q[1];
  // debounce: the level follows s only after it has differed for DEBOUNCE_CYC cycles
  always_comb begin
    flip    = (s != level_q) && (dcnt_q == DW'(DEBOUNCE_CYC - 1));
    dcnt_d  = ((s == level_q) || flip) ? '0 : dcnt_q + 1'b1;
    level_d = flip ? s : level_q;
    press_d = flip & s;
    rel_d   = flip & ~s;
  end
  // repeat FSM: step on press, after the initial delay, then at the repeat rate; release wins
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    step_d  = 1'b0;
    if (rel_d) begin
      state_d = IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (press_d) begin
          state_d = DELAY;
          rcnt_d  = '0;
          step_d  = 1'b1;
        end
        DELAY: if (REPEAT_EN != 0) begin
          if (rcnt_q == RW'(REPEAT_DELAY_CYC - 1)) begin
            state_d = REPEAT;
            rcnt_d  = '0;
            step_d  = 1'b1;
          end else rcnt_d = rcnt_q + 1'b1;
        end
        REPEAT: if (rcnt_q == RW'(REPEAT_RATE_CYC - 1)) begin
          rcnt_d = '0;
          step_d = 1'b1;
        end else rcnt_d = rcnt_q + 1'b1;
        default: begin
          state_d = IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end
  // state registers; sync chain resets to the released (high) raw level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      dcnt_q  <= '0;
      rcnt_q  <= '0;
      state_q <= IDLE;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      dcnt_q  <= dcnt_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      step_q  <= step_d;
    end
  end
  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign step_o    = step_q;
endmodule

module key_conditioner #(
  parameter int N_KEYS           = 2,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 25_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000,
  parameter int REPEAT_EN        = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] step_pulse
);
  genvar i;
  for (i = 0; i < N_KEYS; i++) begin : g_ch
    key_conditioner_ch #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC(REPEAT_RATE_CYC),
      .REPEAT_EN(REPEAT_EN)
    ) u_ch (
      .clk_i(CLOCK_50),
      .rst_ni(reset),
      .key_n_i(key_n[i]),
      .level_o(key_level[i]),
      .press_o(press_pulse[i]),
      .release_o(release_pulse[i]),
      .step_o(step_pulse[i])
    );
  end
endmodule
